rs544522_enc_frame_ctrl: RTL and testbench
==========================================

// Module: rs544522_enc_frame_ctrl
// PURPOSE
//  Frame sequencer in front of the L=7 parallel RS(544,522) parity core.
//  - Accepts message beats of 7 lanes on a valid/ready stream.
//  - Inserts ZP=3 leading zeros and realigns lanes so the core sees 75 full blocks.
//  - Drives the core's start/valid/last signals and captures its 22 parity symbols.
//  - Presents the parity on a valid/ready output, holding it until it is taken.
// PARAMETERS
//  W    10   symbol width (GF(2^10))
//  L    7    lanes per beat
//  K    522  message symbols per frame
//  R    22   parity symbols
//  ZP   3    leading zero pad
//  Derived:
//  - NB = (K+ZP)/L = 75 beats per frame.
//  - LV = L-ZP = 4 valid lanes in the last input beat.
//  - Elaboration fails ($fatal) if (K+ZP)%L != 0.
// PORTS
//  clk_i                in   1      clock
//  rst_ni               in   1      async reset, active low
//  in_valid_i           in   1      message beat valid
//  in_ready_o           out  1      beat accepted when valid&ready
//  in_last_i            in   1      last beat of frame
//  in_sym_i[0:L-1]      in   W      lane0 = highest-degree symbol of the beat
//  core_start_o         out  1      to core: first block of frame
//  core_valid_o         out  1      to core: block valid
//  core_last_o          out  1      to core: final (75th) block
//  core_blk_o[0:L-1]    out  W      to core: realigned block
//  core_par_valid_i     in   1      from core: parity valid
//  core_par_i[0:R-1]    in   W      from core: p[21..0], index i = coeff x^i
//  par_valid_o          out  1      parity available
//  par_ready_i          in   1      downstream takes parity
//  par_o[0:R-1]         out  W      held parity, same index order as the core
//  busy_o               out  1      state != IDLE
//  err_o                out  1      1-cycle pulse on framing error
// BEHAVIOUR
//  Clock and reset:
//  - Single clock clk_i.
//  - rst_ni is asynchronous, active low. All flops clear on reset.
//  - State after reset: IDLE; beat counter bc=0; carry register cr[0:2]=0.
//  - Reset values: all core_* outputs 0, par_valid_o=0, par_o=0, err_o=0, busy_o=0.
//  - Reset asserted mid-frame aborts the frame. No parity is emitted.
//  FSM (IDLE -> FEED -> WAIT_PAR -> HOLD -> IDLE):
//  - in_ready_o = (state==IDLE) | (state==FEED).
//  - IDLE: an accepted beat is beat 0. Go to FEED, bc=1.
//  - FEED: each accepted beat increments bc.
//  - After beat NB-1 (bc hits 74), go to WAIT_PAR.
//  - WAIT_PAR: on core_par_valid_i, register core_par_i into par_o and go to HOLD.
//  - HOLD: par_valid_o=1, par_o stable. On par_ready_i, go to IDLE.
//  - Back-to-back frames: the next frame's beat 0 is accepted earliest in the cycle after the HOLD handshake.
//  Realignment (registered, 1-cycle latency from accept to core_* outputs):
//  - Block of beat b = {cr[0..2], in_sym_i[0..3]}.
//  - cr takes in_sym_i[4..6] on each accept.
//  - cr is forced to 0 for beat 0, so block 0 = {0,0,0,in[0..3]}.
//  - Beat 74: lanes 4..6 are ignored; block 74 = {cr, in[0..3]}.
//  - core_start_o=1 only with block 0.
//  - core_last_o=1 only with block 74.
//  - core_valid_o=1 exactly in the cycle after each accept, otherwise 0.
//  - core_blk_o holds its last value when not valid.
//  Framing errors (err_o pulses in the cycle after the offending accept):
//  - in_last_i=1 at bc<74: frame dropped, no core_last_o, return to IDLE.
//    The next frame's core_start_o clears the core.
//  - in_last_i=0 at bc=74: the beat is still treated as the last beat; the frame completes normally.
//  - in_valid_i in WAIT_PAR/HOLD: not accepted (ready=0). This is not an error.
//  - Simultaneous par_ready_i and a new in_valid_i in HOLD: the handshake completes; the beat waits for IDLE.
// CONFIGURATION
//  RS_ENC_CTRL_STATS_EN defined:
//  - Adds output frm_cnt_o[15:0]: +1 on each parity handshake.
//  - Adds output err_cnt_o[15:0]: +1 on each err_o.
//  - Both counters saturate at 16'hFFFF and reset to 0.
//  RS_ENC_CTRL_STATS_EN undefined:
//  - The ports and counters are absent. All other behaviour is identical.
// TESTING
//  T1: random frame of 75 beats, in_last_i on beat 74, par_ready_i=1.
//      -> core sees block0[0..2]=0 and start on block 0 only, last on block 74 only.
//      -> par_o matches the serial LFSR model; the serial check of codeword 544 gives remainder 0.
//  T2: par_ready_i held 0 for 20 cycles after par_valid_o rises.
//      -> par_o stable, in_ready_o=0 throughout; the next frame starts one cycle after the handshake.
//  T3: in_last_i at beat 40.
//      -> err_o=1 once, no core_last_o, no par_valid_o, state IDLE.
//      -> A following good frame gives a correct parity.
//  T4: beat 74 sent with in_last_i=0.
//      -> err_o pulse, parity still valid and correct.
//  T5: in_valid_i toggled randomly at 50% during FEED.
//      -> core blocks are identical to T1 for the same data; bc reaches 74 only after 75 accepts.
//  T6: rst_ni pulsed low at beat 30, then a full frame.
//      -> all outputs 0 during reset, no stale parity; the new frame parity is correct.
//      -> With STATS_EN: frm_cnt_o=1, err_cnt_o=0.

Source files
------------

// File: rtl/rs544522_enc_frame_ctrl.sv
// Frame sequencer for the L-lane RS(544,522) parity core: zero-pad realignment, core handshake, parity hold.
// Optional statistics counters are enabled with the RS_ENC_CTRL_STATS_EN macro.
module rs544522_enc_frame_ctrl #(
  parameter int W  = 10,
  parameter int L  = 7,
  parameter int K  = 522,
  parameter int R  = 22,
  parameter int ZP = 3
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic         in_last_i,
  input  logic [W-1:0] in_sym_i [0:L-1],
  output logic         core_start_o,
  output logic         core_valid_o,
  output logic         core_last_o,
  output logic [W-1:0] core_blk_o [0:L-1],
  input  logic         core_par_valid_i,
  input  logic [W-1:0] core_par_i [0:R-1],
  output logic         par_valid_o,
  input  logic         par_ready_i,
  output logic [W-1:0] par_o [0:R-1],
  output logic         busy_o,
`ifdef RS_ENC_CTRL_STATS_EN
  output logic [15:0]  frm_cnt_o,
  output logic [15:0]  err_cnt_o,
`endif
  output logic         err_o
);

  localparam int NB  = (K + ZP) / L;
  localparam int LV  = L - ZP;
  localparam int BCW = $clog2(NB);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FEED = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  if ((K + ZP) % L != 0) begin : g_bad_cfg
    $fatal(1, "rs544522_enc_frame_ctrl: K+ZP must be a multiple of L");
  end

  logic [1:0]     r_state;
  logic [BCW-1:0] r_bc;
  logic           r_err;
  logic           r_core_start;
  logic           r_core_valid;
  logic           r_core_last;
  logic           r_par_valid;
  logic [W-1:0]   r_cr  [0:ZP-1];
  logic [W-1:0]   r_blk [0:L-1];
  logic [W-1:0]   r_par [0:R-1];

  logic           w_accept;
  logic [BCW-1:0] w_idx;
  logic           w_first;
  logic           w_final;
  logic [1:0]     w_state_nxt;
  logic [BCW-1:0] w_bc_nxt;
  logic           w_err_nxt;

  assign in_ready_o = (r_state == S_IDLE) | (r_state == S_FEED);
  assign w_accept   = in_valid_i & in_ready_o;
  // In IDLE the accepted beat is always beat 0, whatever bc holds.
  assign w_idx      = (r_state == S_IDLE) ? {BCW{1'b0}} : r_bc;
  assign w_first    = (w_idx == {BCW{1'b0}});
  assign w_final    = (w_idx == BCW'(NB - 1));

  // Next-state, beat-counter and framing-error decode
  always_comb begin
    w_state_nxt = r_state;
    w_bc_nxt    = r_bc;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE, S_FEED: begin
        if (w_accept) begin
          if (w_final) begin
            w_state_nxt = S_WAIT;
            w_bc_nxt    = {BCW{1'b0}};
            w_err_nxt   = ~in_last_i;
          end else if (in_last_i) begin
            w_state_nxt = S_IDLE;
            w_bc_nxt    = {BCW{1'b0}};
            w_err_nxt   = 1'b1;
          end else begin
            w_state_nxt = S_FEED;
            w_bc_nxt    = w_idx + BCW'(1);
          end
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_WAIT: begin
        if (core_par_valid_i) begin
          w_state_nxt = S_HOLD;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_HOLD: begin
        if (par_ready_i) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_HOLD;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_bc_nxt    = {BCW{1'b0}};
      end
    endcase
  end

  // FSM state, beat counter and error pulse
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_bc    <= {BCW{1'b0}};
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_bc    <= w_bc_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Realignment: block = {carry, first LV lanes}; carry takes the remaining ZP lanes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_core_start <= 1'b0;
      r_core_valid <= 1'b0;
      r_core_last  <= 1'b0;
      for (int j = 0; j < ZP; j++) r_cr[j] <= {W{1'b0}};
      for (int j = 0; j < L; j++) r_blk[j] <= {W{1'b0}};
    end else if (w_accept) begin
      r_core_start <= w_first;
      r_core_valid <= 1'b1;
      r_core_last  <= w_final;
      for (int j = 0; j < ZP; j++) begin
        r_blk[j] <= w_first ? {W{1'b0}} : r_cr[j];
        r_cr[j]  <= in_sym_i[LV+j];
      end
      for (int j = 0; j < LV; j++) r_blk[ZP+j] <= in_sym_i[j];
    end else begin
      r_core_start <= 1'b0;
      r_core_valid <= 1'b0;
      r_core_last  <= 1'b0;
    end
  end

  // Parity capture from the core and hold until the downstream handshake
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_par_valid <= 1'b0;
      for (int i = 0; i < R; i++) r_par[i] <= {W{1'b0}};
    end else if ((r_state == S_WAIT) && core_par_valid_i) begin
      r_par_valid <= 1'b1;
      for (int i = 0; i < R; i++) r_par[i] <= core_par_i[i];
    end else if ((r_state == S_HOLD) && par_ready_i) begin
      r_par_valid <= 1'b0;
    end else begin
      r_par_valid <= r_par_valid;
    end
  end

`ifdef RS_ENC_CTRL_STATS_EN
  logic [15:0] r_frm_cnt;
  logic [15:0] r_err_cnt;

  // Saturating frame and error counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_frm_cnt <= 16'd0;
      r_err_cnt <= 16'd0;
    end else begin
      if ((r_state == S_HOLD) && par_ready_i && (r_frm_cnt != 16'hFFFF)) begin
        r_frm_cnt <= r_frm_cnt + 16'd1;
      end else begin
        r_frm_cnt <= r_frm_cnt;
      end
      if (w_err_nxt && (r_err_cnt != 16'hFFFF)) begin
        r_err_cnt <= r_err_cnt + 16'd1;
      end else begin
        r_err_cnt <= r_err_cnt;
      end
    end
  end

  assign frm_cnt_o = r_frm_cnt;
  assign err_cnt_o = r_err_cnt;
`endif

  assign core_start_o = r_core_start;
  assign core_valid_o = r_core_valid;
  assign core_last_o  = r_core_last;
  assign core_blk_o   = r_blk;
  assign par_valid_o  = r_par_valid;
  assign par_o        = r_par;
  assign busy_o       = (r_state != S_IDLE);
  assign err_o        = r_err;

endmodule

// File: tb/tb_rs544522_enc_frame_ctrl.sv
// Directed bench for rs544522_enc_frame_ctrl; the bench plays the parity core and the downstream sink.
module tb_rs544522_enc_frame_ctrl;
  localparam int W  = 10;
  localparam int L  = 7;
  localparam int R  = 22;
  localparam int NB = 75;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, in_last;
  logic [W-1:0] in_sym [0:L-1];
  logic         core_start, core_valid, core_last;
  logic [W-1:0] core_blk [0:L-1];
  logic         core_par_valid;
  logic [W-1:0] core_par [0:R-1];
  logic         par_valid, par_ready;
  logic [W-1:0] par [0:R-1];
  logic         busy, err;
`ifdef RS_ENC_CTRL_STATS_EN
  logic [15:0]  frm_cnt, err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rs544522_enc_frame_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_last_i(in_last), .in_sym_i(in_sym),
    .core_start_o(core_start), .core_valid_o(core_valid), .core_last_o(core_last),
    .core_blk_o(core_blk), .core_par_valid_i(core_par_valid), .core_par_i(core_par),
    .par_valid_o(par_valid), .par_ready_i(par_ready), .par_o(par),
    .busy_o(busy),
`ifdef RS_ENC_CTRL_STATS_EN
    .frm_cnt_o(frm_cnt), .err_cnt_o(err_cnt),
`endif
    .err_o(err)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] sym(input int seed, input int b, input int j);
    return W'((seed * 97 + (b * 7 + j) * 37 + b * b) & 1023);
  endfunction

  function automatic logic [W-1:0] exp_par(input int seed, input int i);
    return W'((seed * 13 + i * 29 + 5) & 1023);
  endfunction

  // Sends nbeats beats; last_flag is driven on the final one. Checks each realigned block.
  task automatic send_frame(input int seed, input int nbeats, input bit last_flag, input bit gaps);
    int to;
    logic [W-1:0] e;
    bit exp_err;
    for (int b = 0; b < nbeats; b++) begin
      if (gaps) begin
        int g;
        g = 0;
        while (g < 8 && $urandom_range(1, 0) == 1) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
          check_val("gap_core_valid", 32'(core_valid), 32'd0);
          g++;
        end
      end
      in_valid = 1'b1;
      in_last  = (b == nbeats - 1) ? last_flag : 1'b0;
      for (int j = 0; j < L; j++) in_sym[j] = sym(seed, b, j);
      to = 0;
      @(negedge clk);
      while (!in_ready && to < 100) begin
        @(negedge clk);
        to++;
      end
      if (!in_ready) begin
        check_val("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      exp_err = (b == nbeats - 1) &&
                (((b < NB - 1) && last_flag) || ((b == NB - 1) && !last_flag));
      check_val($sformatf("core_valid b%0d", b), 32'(core_valid), 32'd1);
      check_val($sformatf("core_start b%0d", b), 32'(core_start), 32'(b == 0));
      check_val($sformatf("core_last b%0d", b), 32'(core_last), 32'(b == NB - 1));
      check_val($sformatf("err b%0d", b), 32'(err), 32'(exp_err));
      for (int j = 0; j < L; j++) begin
        if (j < 3) e = (b == 0) ? '0 : sym(seed, b - 1, 4 + j);
        else       e = sym(seed, b, j - 3);
        check_val($sformatf("blk b%0d l%0d", b, j), 32'(core_blk[j]), 32'(e));
      end
    end
  endtask

  // Acts as the core returning parity, then as the sink holding off for hold cycles.
  task automatic respond(input int seed, input int hold);
    check_val("wait_in_ready", 32'(in_ready), 32'd0);
    check_val("wait_busy", 32'(busy), 32'd1);
    repeat (3) begin
      @(posedge clk); #1;
      check_val("wait_par_valid", 32'(par_valid), 32'd0);
    end
    for (int i = 0; i < R; i++) core_par[i] = exp_par(seed, i);
    core_par_valid = 1'b1;
    @(posedge clk); #1;
    core_par_valid = 1'b0;
    for (int i = 0; i < R; i++) core_par[i] = ~exp_par(seed, i);
    check_val("par_valid_rise", 32'(par_valid), 32'd1);
    check_val("hold_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < R; i++)
      check_val($sformatf("par%0d", i), 32'(par[i]), 32'(exp_par(seed, i)));
    if (hold > 0) begin
      in_valid = 1'b1;
      for (int j = 0; j < L; j++) in_sym[j] = W'(10'h155);
      repeat (hold) begin
        @(posedge clk); #1;
        check_val("hold_par_valid", 32'(par_valid), 32'd1);
        check_val("hold_par0", 32'(par[0]), 32'(exp_par(seed, 0)));
        check_val("hold_par21", 32'(par[R-1]), 32'(exp_par(seed, R - 1)));
        check_val("hold_ready", 32'(in_ready), 32'd0);
        check_val("hold_core_valid", 32'(core_valid), 32'd0);
      end
    end
    par_ready = 1'b1;
    @(posedge clk); #1;
    par_ready = 1'b0;
    in_valid  = 1'b0;
    check_val("post_hs_par_valid", 32'(par_valid), 32'd0);
    check_val("post_hs_busy", 32'(busy), 32'd0);
    check_val("post_hs_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_val({pfx, "_core_valid"}, 32'(core_valid), 32'd0);
    check_val({pfx, "_core_start"}, 32'(core_start), 32'd0);
    check_val({pfx, "_core_last"}, 32'(core_last), 32'd0);
    check_val({pfx, "_blk0"}, 32'(core_blk[0]), 32'd0);
    check_val({pfx, "_blk6"}, 32'(core_blk[L-1]), 32'd0);
    check_val({pfx, "_par_valid"}, 32'(par_valid), 32'd0);
    check_val({pfx, "_par0"}, 32'(par[0]), 32'd0);
    check_val({pfx, "_par21"}, 32'(par[R-1]), 32'd0);
    check_val({pfx, "_err"}, 32'(err), 32'd0);
    check_val({pfx, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_last = 1'b0; core_par_valid = 1'b0; par_ready = 1'b0;
    for (int j = 0; j < L; j++) in_sym[j] = '0;
    for (int i = 0; i < R; i++) core_par[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // T1: good frame, immediate handshake
    send_frame(1, NB, 1'b1, 1'b0);
    respond(1, 0);

    // T2: parity held off for 20 cycles while a beat is offered
    send_frame(2, NB, 1'b1, 1'b0);
    respond(2, 20);

    // T3: early last at beat 40, then a good frame
    send_frame(3, 41, 1'b1, 1'b0);
    @(posedge clk); #1;
    check_val("t3_err_pulse_end", 32'(err), 32'd0);
    check_val("t3_core_valid", 32'(core_valid), 32'd0);
    check_val("t3_busy", 32'(busy), 32'd0);
    check_val("t3_par_valid", 32'(par_valid), 32'd0);
    check_val("t3_in_ready", 32'(in_ready), 32'd1);
    send_frame(4, NB, 1'b1, 1'b0);
    respond(4, 0);

    // T4: missing last on beat 74
    send_frame(5, NB, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_val("t4_err_pulse_end", 32'(err), 32'd0);
    respond(5, 0);

    // T5: same data as T1 with random valid gaps
    send_frame(1, NB, 1'b1, 1'b1);
    respond(1, 0);

    // T6: reset at beat 30, then a full frame
    send_frame(6, 30, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_frame(7, NB, 1'b1, 1'b0);
    respond(7, 0);
`ifdef RS_ENC_CTRL_STATS_EN
    check_val("t6_frm_cnt", 32'(frm_cnt), 32'd1);
    check_val("t6_err_cnt", 32'(err_cnt), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
